or1200_secure_ld_steer: RTL and testbench
=========================================

// Module: or1200_secure_ld_steer
// PURPOSE
//  Downstream consumer of the load-insn flag FIFO. Tracks outstanding issued loads.
//  On each dcache load-data return it pops the per-load secure flag and routes the data.
//  Secure loads go through the decrypt unit (req/ack handshake); plain loads bypass it.
//  Completed data goes to the LSU write-back path.
//  Stalls the pipeline while a return is being steered.
// PARAMETERS
//  aw  4   flag-FIFO address width; max outstanding loads = 2**aw
//  dw  32  load data width
// PORTS
//  clk          in   1       core clock, all state on rising edge
//  rst          in   1       asynchronous, active-low reset
//  ld_issue_i   in   1       decoder pushed one load flag into FIFO (same pulse as FIFO ce_w)
//  dcpu_ack_i   in   1       dcache load data valid, single-cycle pulse
//  dcpu_dat_i   in   dw      dcache load data, valid with dcpu_ack_i
//  fifo_pop_o   out  1       FIFO ce_r; flag appears on fifo_flag_i next cycle
//  fifo_flag_i  in   1       FIFO dout: 1 = secure load
//  dec_req_o    out  1       decrypt request, held until dec_ack_i
//  dec_dat_o    out  dw      ciphertext to decrypt unit
//  dec_ack_i    in   1       decrypt done, single-cycle pulse
//  dec_dat_i    in   dw      plaintext, valid with dec_ack_i
//  lsu_ack_o    out  1       one-cycle completion pulse to LSU
//  lsu_dat_o    out  dw      completed load data, valid with lsu_ack_o
//  stall_o      out  1       high whenever state != IDLE
//  pend_cnt_o   out  aw+1    outstanding (issued, unreturned) loads
//  err_o        out  1       sticky protocol error, cleared only by reset
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, pend_cnt 0, data reg 0, err_o 0.
//  FSM states:
//  - IDLE: on dcpu_ack_i, latch dcpu_dat_i, pulse fifo_pop_o (same cycle), go to RDFLAG.
//  - RDFLAG: sample fifo_flag_i; 1 -> DECREQ, 0 -> DONE.
//  - DECREQ: dec_req_o=1, dec_dat_o=data reg; on dec_ack_i latch dec_dat_i, go to DONE.
//  - DONE: lsu_ack_o=1, lsu_dat_o=data reg, go to IDLE.
//  Latency, ack at cycle T:
//  - bypass: lsu_ack_o at T+2.
//  - secure: dec_req_o from T+2; lsu_ack_o 1 cycle after dec_ack_i.
//  dec_ack_i outside DECREQ: ignored.
//  pend_cnt update:
//  - +1 on ld_issue_i; -1 on an accepted pop; both in same cycle -> unchanged.
//  - saturates at 0 and 2**aw.
//  Error cases (each sets err_o):
//  - overflow: ld_issue_i with pend_cnt==2**aw and no pop that cycle; count unchanged.
//  - underflow: dcpu_ack_i in IDLE with pend_cnt==0.
//    No pop is issued; data reg is forced to 0 (fail closed); FSM goes straight to DONE.
//  - dcpu_ack_i while state != IDLE: data dropped, no pop. The dcache must honour stall_o.
//  - Simultaneous ld_issue_i and dcpu_ack_i in IDLE is legal.
//    Count rule above; the pop reads the oldest flag.
//  Reset asserted mid-operation: FSM returns to IDLE at once.
//    In-flight decrypt result is discarded; FIFO must be reset together.
// STRUCTURE
//  Shared defines (or1200_defines.v):
//  - `OR1200_SLS_IDLE/RDFLAG/DECREQ/DONE: 2-bit state encodings.
//  - `OR1200_SLS_DW: default data width.
//  One sub-module, or1200_secure_ld_cnt.
//  - Up/down occupancy counter with saturation.
//  - Outputs pend_cnt_o and overflow/underflow strobes.
//  FSM, data register and err_o stay in the top.
// TESTING
//  1 Bypass: issue 1 (flag 0), ack 0xA5A5A5A5 at T.
//    -> pop at T, lsu_ack_o at T+2 with 0xA5A5A5A5, dec_req_o never high, pend 1->0.
//  2 Secure: flag 1, ack 0x11223344, dec_ack_i 3 cycles after req with 0xCAFEF00D.
//    -> dec_dat_o=0x11223344 held, lsu_ack_o next cycle with 0xCAFEF00D.
//  3 Order: issue flags 1,0,1, three acks each waiting on stall_o.
//    -> routes secure, bypass, secure; pend 3->0; err_o 0.
//  4 Full/overflow (aw=4): 16 issues -> pend 16.
//    17th issue -> err_o=1, pend 16. Issue+ack in same cycle at 16 -> pend 16, no error.
//  5 Underflow: ack with pend 0 -> no pop, lsu_ack_o at T+1 with data 0, err_o=1.
//  6 Reset in DECREQ: rst low -> stall_o/dec_req_o 0 at once; later dec_ack_i gives no lsu_ack_o.

Source files
------------

// File: rtl/or1200_secure_ld_steer_pkg.sv
// Shared types and defaults for the secure load-data steering block.
package or1200_secure_ld_steer_pkg;

  // Default flag-FIFO address width; up to 2**aw loads may be outstanding.
  localparam int SLS_AW = 4;
  // Default load data width.
  localparam int SLS_DW = 32;

  // Steering FSM state encodings.
  typedef enum logic [1:0] {
    SLS_IDLE   = 2'd0,
    SLS_RDFLAG = 2'd1,
    SLS_DECREQ = 2'd2,
    SLS_DONE   = 2'd3
  } sls_state_e;

endpackage

// File: rtl/or1200_secure_ld_cnt.sv
// Outstanding-load occupancy counter: counts issued loads that have not yet
// had their data returned. Saturates at 0 and 2**aw, and flags attempts to
// go past either end.
module or1200_secure_ld_cnt #(
  parameter int aw = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  input  logic        pop_req,
  output logic        pop_ok,
  output logic        ovf,
  output logic        udf,
  output logic [aw:0] cnt
);

  localparam logic [aw:0] CNT_MAX = {1'b1, {aw{1'b0}}};
  localparam logic [aw:0] CNT_ONE = {{aw{1'b0}}, 1'b1};

  logic at_zero;
  logic at_max;

  assign at_zero = (cnt == '0);
  assign at_max  = (cnt == CNT_MAX);

  // A pop is only granted when there is a flag to pop.
  assign pop_ok = pop_req && !at_zero;
  assign udf    = pop_req && at_zero;
  // An issue at full that is not offset by a pop has nowhere to go.
  assign ovf    = inc && !pop_ok && at_max;

  // Up/down count; a simultaneous issue and pop leave the count unchanged.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (inc && !pop_ok && !at_max) begin
      cnt <= cnt + CNT_ONE;
    end else if (pop_ok && !inc) begin
      cnt <= cnt - CNT_ONE;
    end
  end

endmodule

// File: rtl/or1200_secure_ld_steer.sv
// Secure load steering: pops the per-load secure flag on each dcache load
// return and routes the data through the decrypt unit (secure) or straight
// to the LSU write-back path (plain). Stalls the pipeline while steering.
//
//   state  | meaning
//   IDLE   | waiting for a dcache load return
//   RDFLAG | flag popped last cycle, sample it to pick the route
//   DECREQ | ciphertext offered to the decrypt unit, waiting for its ack
//   DONE   | completed data presented to the LSU for one cycle
module or1200_secure_ld_steer
  import or1200_secure_ld_steer_pkg::*;
#(
  parameter int aw = SLS_AW,
  parameter int dw = SLS_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ld_issue_i,
  input  logic          dcpu_ack_i,
  input  logic [dw-1:0] dcpu_dat_i,
  output logic          fifo_pop_o,
  input  logic          fifo_flag_i,
  output logic          dec_req_o,
  output logic [dw-1:0] dec_dat_o,
  input  logic          dec_ack_i,
  input  logic [dw-1:0] dec_dat_i,
  output logic          lsu_ack_o,
  output logic [dw-1:0] lsu_dat_o,
  output logic          stall_o,
  output logic [aw:0]   pend_cnt_o,
  output logic          err_o
);

  sls_state_e    state_q;
  sls_state_e    state_d;
  logic [dw-1:0] data_q;
  logic [dw-1:0] data_d;
  logic          pop_req;
  logic          pop_ok;
  logic          ovf;
  logic          udf;
  logic          late_ack;

  // Only a return seen in IDLE is consumed; anything else is a dcache that
  // ignored stall_o, and that data is dropped.
  assign pop_req  = dcpu_ack_i && (state_q == SLS_IDLE);
  assign late_ack = dcpu_ack_i && (state_q != SLS_IDLE);

  assign fifo_pop_o = pop_ok;

  or1200_secure_ld_cnt #(
    .aw(aw)
  ) u_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc     (ld_issue_i),
    .pop_req (pop_req),
    .pop_ok  (pop_ok),
    .ovf     (ovf),
    .udf     (udf),
    .cnt     (pend_cnt_o)
  );

  // State and data register; reset discards any in-flight decrypt result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= SLS_IDLE;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  // Next-state, data capture and output decode.
  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    dec_req_o = 1'b0;
    dec_dat_o = '0;
    lsu_ack_o = 1'b0;
    lsu_dat_o = '0;
    stall_o   = (state_q != SLS_IDLE);
    case (state_q)
      SLS_IDLE: begin
        if (dcpu_ack_i) begin
          if (pop_ok) begin
            data_d  = dcpu_dat_i;
            state_d = SLS_RDFLAG;
          end else begin
            // No flag to say whether this is secure: fail closed with zero.
            data_d  = '0;
            state_d = SLS_DONE;
          end
        end
      end
      SLS_RDFLAG: begin
        state_d = fifo_flag_i ? SLS_DECREQ : SLS_DONE;
      end
      SLS_DECREQ: begin
        dec_req_o = 1'b1;
        dec_dat_o = data_q;
        if (dec_ack_i) begin
          data_d  = dec_dat_i;
          state_d = SLS_DONE;
        end
      end
      SLS_DONE: begin
        lsu_ack_o = 1'b1;
        lsu_dat_o = data_q;
        state_d   = SLS_IDLE;
      end
      default: begin
        state_d = SLS_IDLE;
      end
    endcase
  end

  // Sticky protocol error; only reset clears it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_o <= 1'b0;
    end else if (ovf || udf || late_ack) begin
      err_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_or1200_secure_ld_steer.sv
// Self-checking bench for or1200_secure_ld_steer: directed scenarios plus a
// randomized run against a transaction-level reference model.
module tb_or1200_secure_ld_steer;

  localparam int AW   = 4;
  localparam int DW   = 32;
  localparam int MAXP = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ld_issue_i = 1'b0;
  logic          issue_flag = 1'b0;
  logic          dcpu_ack_i = 1'b0;
  logic [DW-1:0] dcpu_dat_i = '0;
  logic          fifo_pop_o;
  logic          fifo_flag_i;
  logic          dec_req_o;
  logic [DW-1:0] dec_dat_o;
  logic          dec_ack_i = 1'b0;
  logic [DW-1:0] dec_dat_i = '0;
  logic          lsu_ack_o;
  logic [DW-1:0] lsu_dat_o;
  logic          stall_o;
  logic [AW:0]   pend_cnt_o;
  logic          err_o;

  int n_checks = 0;
  int n_fail   = 0;

  // Flag FIFO stand-in feeding the DUT.
  logic fifo_q[$];
  logic flag_q = 1'b0;

  // Reference model: issued-but-unreturned flags in order, count, error.
  logic ref_flags[$];
  int   pend_exp = 0;
  logic err_exp  = 1'b0;

  or1200_secure_ld_steer #(.aw(AW), .dw(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .ld_issue_i  (ld_issue_i),
    .dcpu_ack_i  (dcpu_ack_i),
    .dcpu_dat_i  (dcpu_dat_i),
    .fifo_pop_o  (fifo_pop_o),
    .fifo_flag_i (fifo_flag_i),
    .dec_req_o   (dec_req_o),
    .dec_dat_o   (dec_dat_o),
    .dec_ack_i   (dec_ack_i),
    .dec_dat_i   (dec_dat_i),
    .lsu_ack_o   (lsu_ack_o),
    .lsu_dat_o   (lsu_dat_o),
    .stall_o     (stall_o),
    .pend_cnt_o  (pend_cnt_o),
    .err_o       (err_o)
  );

  // Free-running core clock.
  always #5 clk = ~clk;

  assign fifo_flag_i = flag_q;

  // FIFO behaviour: popped flag shows up next cycle, pop before push.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      fifo_q.delete();
      flag_q <= 1'b0;
    end else begin
      if (fifo_pop_o && fifo_q.size() > 0) flag_q <= fifo_q.pop_front();
      if (ld_issue_i && fifo_q.size() < MAXP) fifo_q.push_back(issue_flag);
    end
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    #1;
    check_val("rst_stall",   64'(stall_o),    64'd0);
    check_val("rst_dec_req", 64'(dec_req_o),  64'd0);
    check_val("rst_lsu_ack", 64'(lsu_ack_o),  64'd0);
    check_val("rst_lsu_dat", 64'(lsu_dat_o),  64'd0);
    check_val("rst_dec_dat", 64'(dec_dat_o),  64'd0);
    check_val("rst_pend",    64'(pend_cnt_o), 64'd0);
    check_val("rst_err",     64'(err_o),      64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    ref_flags.delete();
    pend_exp = 0;
    err_exp  = 1'b0;
  endtask

  // One issue pulse, called right after a falling edge.
  task automatic issue_load(input logic flg);
    ld_issue_i = 1'b1;
    issue_flag = flg;
    @(negedge clk);
    ld_issue_i = 1'b0;
    if (pend_exp == MAXP) begin
      err_exp = 1'b1;
    end else begin
      pend_exp++;
      ref_flags.push_back(flg);
    end
    check_val("issue_pend", 64'(pend_cnt_o), 64'(pend_exp));
    check_val("issue_err",  64'(err_o),      64'(err_exp));
  endtask

  // One complete load return in IDLE with pend>0, optionally with a new
  // issue in the same cycle; secure loads get dec_ack after dly cycles.
  task automatic do_load(input logic iss, input logic iss_flag, input logic [DW-1:0] dat,
                         input logic [DW-1:0] plain, input int dly);
    logic sec;
    sec = ref_flags.pop_front();
    dcpu_ack_i = 1'b1;
    dcpu_dat_i = dat;
    ld_issue_i = iss;
    issue_flag = iss_flag;
    #1;
    check_val("pop", 64'(fifo_pop_o), 64'd1);
    @(negedge clk);
    dcpu_ack_i = 1'b0;
    dcpu_dat_i = '0;
    ld_issue_i = 1'b0;
    if (iss) ref_flags.push_back(iss_flag);
    else pend_exp--;
    check_val("pend_after_pop", 64'(pend_cnt_o), 64'(pend_exp));
    check_val("stall_busy",     64'(stall_o),    64'd1);
    check_val("no_early_ack",   64'(lsu_ack_o),  64'd0);
    @(negedge clk);
    if (!sec) begin
      check_val("byp_lsu_ack", 64'(lsu_ack_o), 64'd1);
      check_val("byp_lsu_dat", 64'(lsu_dat_o), 64'(dat));
      check_val("byp_no_req",  64'(dec_req_o), 64'd0);
    end else begin
      for (int i = 0; i <= dly; i++) begin
        check_val("sec_req",    64'(dec_req_o), 64'd1);
        check_val("sec_dat",    64'(dec_dat_o), 64'(dat));
        check_val("sec_no_ack", 64'(lsu_ack_o), 64'd0);
        if (i < dly) @(negedge clk);
      end
      dec_ack_i = 1'b1;
      dec_dat_i = plain;
      @(negedge clk);
      dec_ack_i = 1'b0;
      dec_dat_i = '0;
      check_val("sec_lsu_ack", 64'(lsu_ack_o), 64'd1);
      check_val("sec_lsu_dat", 64'(lsu_dat_o), 64'(plain));
      check_val("sec_req_off", 64'(dec_req_o), 64'd0);
    end
    @(negedge clk);
    check_val("back_idle", 64'(stall_o),   64'd0);
    check_val("ack_pulse", 64'(lsu_ack_o), 64'd0);
    check_val("load_err",  64'(err_o),     64'(err_exp));
  endtask

  // Stimulus and checks.
  initial begin
    int   nis;
    logic ci;
    @(negedge clk);
    apply_reset();

    // Bypass load.
    issue_load(1'b0);
    do_load(1'b0, 1'b0, 32'hA5A5_A5A5, 32'h0, 0);
    check_val("t1_pend", 64'(pend_cnt_o), 64'd0);

    // Secure load, decrypt acks 3 cycles after request.
    issue_load(1'b1);
    do_load(1'b0, 1'b0, 32'h1122_3344, 32'hCAFE_F00D, 3);

    // Ordering: secure, bypass, secure.
    issue_load(1'b1);
    issue_load(1'b0);
    issue_load(1'b1);
    check_val("t3_pend3", 64'(pend_cnt_o), 64'd3);
    do_load(1'b0, 1'b0, 32'h0000_0001, 32'h1000_0001, 1);
    do_load(1'b0, 1'b0, 32'h0000_0002, 32'h1000_0002, 0);
    do_load(1'b0, 1'b0, 32'h0000_0003, 32'h1000_0003, 2);
    check_val("t3_pend0", 64'(pend_cnt_o), 64'd0);
    check_val("t3_err",   64'(err_o),      64'd0);

    // Randomized legal traffic, with stray decrypt acks in IDLE.
    repeat (40) begin
      nis = int'($urandom_range(0, 3));
      for (int k = 0; k < nis; k++)
        if (pend_exp < MAXP) issue_load(1'($urandom_range(0, 1)));
      if (pend_exp > 0) begin
        ci = 1'($urandom_range(0, 3) == 0);
        do_load(ci, 1'($urandom_range(0, 1)), $urandom, $urandom, int'($urandom_range(0, 4)));
      end
      if ($urandom_range(0, 3) == 0) begin
        dec_ack_i = 1'b1;
        dec_dat_i = $urandom;
        @(negedge clk);
        dec_ack_i = 1'b0;
        dec_dat_i = '0;
        check_val("stray_dec_ack", 64'(lsu_ack_o), 64'd0);
        check_val("stray_stall",   64'(stall_o),   64'd0);
      end
    end
    check_val("rand_err", 64'(err_o), 64'd0);

    // Full and overflow.
    apply_reset();
    for (int k = 0; k < MAXP; k++) issue_load(1'($urandom_range(0, 1)));
    check_val("full_pend", 64'(pend_cnt_o), 64'd16);
    do_load(1'b1, 1'b0, 32'h5555_0000, 32'h6666_0000, 1);
    check_val("full_swap_pend", 64'(pend_cnt_o), 64'd16);
    check_val("full_swap_err",  64'(err_o),      64'd0);
    issue_load(1'b1);
    check_val("ovf_err",  64'(err_o),      64'd1);
    check_val("ovf_pend", 64'(pend_cnt_o), 64'd16);

    // Underflow: fail closed with zero data.
    apply_reset();
    dcpu_ack_i = 1'b1;
    dcpu_dat_i = 32'hDEAD_BEEF;
    #1;
    check_val("udf_no_pop", 64'(fifo_pop_o), 64'd0);
    @(negedge clk);
    dcpu_ack_i = 1'b0;
    dcpu_dat_i = '0;
    check_val("udf_lsu_ack", 64'(lsu_ack_o),  64'd1);
    check_val("udf_lsu_dat", 64'(lsu_dat_o),  64'd0);
    check_val("udf_err",     64'(err_o),      64'd1);
    check_val("udf_pend",    64'(pend_cnt_o), 64'd0);
    @(negedge clk);
    check_val("udf_idle", 64'(stall_o), 64'd0);

    // Reset while waiting on the decrypt unit.
    apply_reset();
    issue_load(1'b1);
    dcpu_ack_i = 1'b1;
    dcpu_dat_i = 32'h7777_8888;
    @(negedge clk);
    dcpu_ack_i = 1'b0;
    dcpu_dat_i = '0;
    @(negedge clk);
    check_val("t6_in_decreq", 64'(dec_req_o), 64'd1);
    rst = 1'b0;
    #1;
    check_val("t6_stall_off", 64'(stall_o),   64'd0);
    check_val("t6_req_off",   64'(dec_req_o), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    ref_flags.delete();
    pend_exp = 0;
    err_exp  = 1'b0;
    dec_ack_i = 1'b1;
    dec_dat_i = 32'h9999_AAAA;
    @(negedge clk);
    dec_ack_i = 1'b0;
    dec_dat_i = '0;
    for (int k = 0; k < 3; k++) begin
      check_val("t6_no_lsu_ack", 64'(lsu_ack_o), 64'd0);
      @(negedge clk);
    end
    check_val("t6_pend", 64'(pend_cnt_o), 64'd0);
    check_val("t6_err",  64'(err_o),      64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
